// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: per-requester slot states and the
// depth of the shared ALU pipeline that the completion tags are aligned to.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_INFLIGHT = 2'd1,
    SLOT_HOLD     = 2'd2
  } slot_state_t;

  // Register stages inside the shared alu between valid_in and valid_out.
  // The tag pipeline (tag_s1 -> tag_s2) holds one extra stage to cover the
  // arbiter's own issue register in front of the ALU.
  localparam int ALU_LATENCY = 1;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: picks the first eligible requester
// scanning from ptr upward with wrap at NREQ (NREQ need not be a power of 2).
module rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  logic [IDW-1:0]  cand_idx [NREQ];
  logic [NREQ-1:0] cand_ok;

  genvar gi;

  // Candidate at scan offset gi is (ptr + gi) mod NREQ. One extra bit of
  // headroom keeps ptr + gi from overflowing before the wrap subtraction.
  for (gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum          = {1'b0, ptr} + (IDW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                  : IDW'(sum);
    assign cand_ok[gi]  = eligible[cand_idx[gi]];
  end

  // Priority pick: the lowest scan offset with an eligible requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && cand_ok[k]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
  end

  for (gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign grant[gi] = grant_any && (grant_idx == IDW'(gi));
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NREQ requesters. Accepts at most one
// request per cycle (round-robin), tags each issue with its owner, and
// parks each result in the owner's slot until the owner takes it.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_op,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [NREQ*WIDTH-1:0] resp_result,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic                  alu_op,
  output logic                  alu_valid,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_done,
  output logic                  busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  slot_busy;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic             done_hit;

  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   tag_s1_reg;
  logic [IDW-1:0]   tag_s2_reg;
  logic             tag_v1_reg;
  logic             tag_v2_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  logic             alu_op_reg;
  logic             alu_valid_reg;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  genvar gi;

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_grant (
    .eligible  (eligible),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A completion only counts when a tag is actually travelling with it;
  // stray alu_done pulses with no tag are dropped.
  assign done_hit = alu_done && tag_v2_reg;

  for (gi = 0; gi < NREQ; gi++) begin : g_slot
    slot_state_t      slot_reg;
    logic [WIDTH-1:0] result_reg;

    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];

    // Reset is held out of eligibility so no handshake is ever shown while
    // the block is being cleared.
    assign eligible[gi]  = req_valid[gi] && (slot_reg == SLOT_IDLE) && !reset;
    assign slot_busy[gi] = (slot_reg != SLOT_IDLE);
    assign resp_valid[gi] = (slot_reg == SLOT_HOLD);
    assign resp_result[gi*WIDTH +: WIDTH] = result_reg;

    // Slot lifecycle: claimed on grant, filled by its own tagged completion,
    // released by the response handshake.
    always_ff @(posedge clk) begin
      if (reset) begin
        slot_reg   <= SLOT_IDLE;
        result_reg <= '0;
      end else begin
        case (slot_reg)
          SLOT_IDLE: begin
            if (grant[gi]) slot_reg <= SLOT_INFLIGHT;
          end
          SLOT_INFLIGHT: begin
            if (done_hit && (tag_s2_reg == IDW'(gi))) begin
              slot_reg   <= SLOT_HOLD;
              result_reg <= alu_result;
            end
          end
          SLOT_HOLD: begin
            if (resp_ready[gi]) slot_reg <= SLOT_IDLE;
          end
          default: slot_reg <= SLOT_IDLE;
        endcase
      end
    end
  end

  // Issue stage, owner-tag pipeline and round-robin pointer. Operands hold
  // their last value when nothing is issued; only the strobe drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg       <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= 1'b0;
      alu_valid_reg <= 1'b0;
      tag_s1_reg    <= '0;
      tag_v1_reg    <= 1'b0;
      tag_s2_reg    <= '0;
      tag_v2_reg    <= 1'b0;
    end else begin
      alu_valid_reg <= grant_any;
      tag_v1_reg    <= grant_any;
      if (grant_any) begin
        alu_a_reg  <= a_arr[grant_idx];
        alu_b_reg  <= b_arr[grant_idx];
        alu_op_reg <= req_op[grant_idx];
        tag_s1_reg <= grant_idx;
        ptr_reg    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      tag_s2_reg <= tag_s1_reg;
      tag_v2_reg <= tag_v1_reg;
    end
  end

  assign req_ready = grant;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign alu_valid = alu_valid_reg;
  assign busy      = (|slot_busy) || alu_valid_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a 4-requester instance checked every cycle against
// a transaction-level model (accept -> result visible 3 cycles later), plus
// a 3-requester instance for wrap-around, with directed literal checks.
module tb_alu_arbiter;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 4-requester instance
  logic [N-1:0]   req_valid, req_ready, req_op, resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b, resp_result;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic           alu_op, alu_valid, alu_done, alu_vo, spur, busy;

  // 3-requester instance
  logic [N3-1:0]   req_valid3, req_ready3, req_op3, resp_valid3, resp_ready3;
  logic [N3*W-1:0] req_a3, req_b3, resp_result3;
  logic [W-1:0]    alu_a3, alu_b3, alu_result3;
  logic            alu_op3, alu_valid3, alu_done3, alu_vo3, spur3, busy3;

  alu_arbiter #(.WIDTH(W), .NREQ(N)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid(alu_valid),
    .alu_result(alu_result), .alu_done(alu_done), .busy(busy)
  );

  alu_arbiter #(.WIDTH(W), .NREQ(N3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_result(resp_result3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_valid(alu_valid3),
    .alu_result(alu_result3), .alu_done(alu_done3), .busy(busy3)
  );

  // Shared ALU stand-ins: one register stage, op=1 passes b, op=0 passes a.
  always @(posedge clk) begin
    if (reset) begin
      alu_vo     <= 1'b0;
      alu_result <= '0;
    end else begin
      alu_vo     <= alu_valid;
      alu_result <= alu_op ? alu_b : alu_a;
    end
  end
  always @(posedge clk) begin
    if (reset) begin
      alu_vo3     <= 1'b0;
      alu_result3 <= '0;
    end else begin
      alu_vo3     <= alu_valid3;
      alu_result3 <= alu_op3 ? alu_b3 : alu_a3;
    end
  end
  assign alu_done  = alu_vo | spur;
  assign alu_done3 = alu_vo3 | spur3;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of the 4-requester instance
  bit             model_on = 1'b0;
  bit             m_has [N];
  int             m_age [N];
  logic [W-1:0]   m_res [N];
  logic [W-1:0]   m_rr  [N];
  int             m_ptr;
  bit             m_av;
  logic [W-1:0]   m_aa, m_ab;
  bit             m_aop;
  int             g, idx;
  logic [N-1:0]   e_ready, e_rv;
  logic [N*W-1:0] e_res;
  logic           e_busy;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_has[i] = 1'b0;
      m_age[i] = 0;
      m_res[i] = '0;
      m_rr[i]  = '0;
    end
    m_ptr = 0;
    m_av  = 1'b0;
    m_aa  = '0;
    m_ab  = '0;
    m_aop = 1'b0;
  endtask

  // Compare every cycle, then advance the model to the next cycle.
  always @(negedge clk) begin
    if (model_on) begin
      g = -1;
      if (!reset) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && req_valid[idx] && !m_has[idx]) g = idx;
        end
      end
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      e_busy = m_av;
      for (int i = 0; i < N; i++) begin
        e_rv[i] = m_has[i] && (m_age[i] >= 3);
        e_res[i*W +: W] = m_rr[i];
        if (m_has[i]) e_busy = 1'b1;
      end
      chk("req_ready",   req_ready,   e_ready);
      chk("resp_valid",  resp_valid,  e_rv);
      chk("resp_result", resp_result, e_res);
      chk("alu_valid",   alu_valid,   m_av);
      chk("alu_a",       alu_a,       m_aa);
      chk("alu_b",       alu_b,       m_ab);
      chk("alu_op",      alu_op,      m_aop);
      chk("busy",        busy,        e_busy);
      if (g >= 0)
        $display("req  %0d accepted a=%h b=%h op=%b", g, req_a[g*W +: W], req_b[g*W +: W], req_op[g]);
      for (int i = 0; i < N; i++)
        if (!reset && e_rv[i] && resp_ready[i])
          $display("resp %0d consumed result=%h", i, m_rr[i]);
    end
    if (reset) begin
      model_clear();
      model_on = 1'b1;
    end else if (model_on) begin
      for (int i = 0; i < N; i++) begin
        if (m_has[i]) begin
          if (e_rv[i] && resp_ready[i]) begin
            m_has[i] = 1'b0;
          end else begin
            if (m_age[i] == 2) m_rr[i] = m_res[i];
            if (m_age[i] < 3) m_age[i]++;
          end
        end
      end
      m_av = (g >= 0);
      if (g >= 0) begin
        m_has[g] = 1'b1;
        m_age[g] = 1;
        m_res[g] = req_op[g] ? req_b[g*W +: W] : req_a[g*W +: W];
        m_aa     = req_a[g*W +: W];
        m_ab     = req_b[g*W +: W];
        m_aop    = req_op[g];
        m_ptr    = (g + 1) % N;
      end
    end
  end

  // ---------------- directed stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int served;
  logic [4:0] ready_tbl;

  initial begin
    reset      = 1'b1;
    req_valid  = '0; req_a  = '0; req_b  = '0; req_op  = '0; resp_ready  = '1; spur  = 1'b0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0; resp_ready3 = '1; spur3 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    sample();
    chk("rst_req_ready",   req_ready,   4'h0);
    chk("rst_resp_valid",  resp_valid,  4'h0);
    chk("rst_resp_result", resp_result, 16'h0);
    chk("rst_alu_valid",   alu_valid,   1'b0);
    chk("rst_alu_a",       alu_a,       4'h0);
    chk("rst_busy",        busy,        1'b0);
    chk("rst_busy3",       busy3,       1'b0);

    // Spurious alu_done with no tag in flight must change nothing
    tick();
    spur = 1'b1; spur3 = 1'b1;
    tick();
    spur = 1'b0; spur3 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("spur_resp_valid",  resp_valid,  4'h0);
      chk("spur_busy",        busy,        1'b0);
      chk("spur_resp_valid3", resp_valid3, 3'h0);
      chk("spur_busy3",       busy3,       1'b0);
      tick();
    end

    // Single request on requester 1, op=1 -> b
    req_valid = 4'b0010; req_a[7:4] = 4'h3; req_b[7:4] = 4'hA; req_op[1] = 1'b1;
    sample(); chk("single_ready_T", req_ready, 4'b0010);
    tick(); req_valid = '0;
    sample(); chk("single_alu_valid", alu_valid, 1'b1);
    chk("single_alu_b", alu_b, 4'hA);
    chk("single_alu_op", alu_op, 1'b1);
    tick(); sample(); chk("single_resp_T2", resp_valid, 4'b0000);
    tick(); sample(); chk("single_resp_T3", resp_valid, 4'b0010);
    chk("single_result_b", resp_result[7:4], 4'hA);

    // Same requester, op=0 -> a
    tick();
    req_valid = 4'b0010; req_op[1] = 1'b0;
    sample(); chk("single2_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    tick(); tick();
    sample(); chk("single2_resp", resp_valid, 4'b0010);
    chk("single2_result_a", resp_result[7:4], 4'h3);
    repeat (2) tick();

    // All four requesting continuously: strict rotation 0,1,2,3,0,1,2,3
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = W'(15 - i);
      req_op[i]       = i[0];
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("rr_grant_order", req_ready, 64'(1) << (k % 4));
      tick();
    end
    req_valid = '0;
    repeat (5) tick();

    // Backpressure on requester 2 while the others keep going
    pulse_reset();
    req_a[11:8] = 4'h5; req_b[11:8] = 4'h9; req_op[2] = 1'b0;
    resp_ready = 4'b1011;
    req_valid  = 4'hF;
    repeat (5) tick();
    served = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      chk("bp_hold_valid",  resp_valid[2],     1'b1);
      chk("bp_hold_result", resp_result[11:8], 4'h5);
      chk("bp_no_regrant",  req_ready[2],      1'b0);
      if ((req_ready & 4'b1011) != 4'b0000) served++;
      tick();
    end
    chk("bp_others_served", served >= 5, 1'b1);
    resp_ready = '1;
    req_valid  = '0;
    repeat (6) tick();

    // Consume and new request on requester 0 in the same cycle
    pulse_reset();
    req_valid = 4'b0001;
    ready_tbl = 5'b10001;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("turnaround_ready", req_ready[0], ready_tbl[k]);
      if (k == 3) chk("turnaround_hold", resp_valid[0], 1'b1);
      tick();
    end
    req_valid = '0;
    repeat (5) tick();

    // Reset in the cycle the ALU reports completion
    req_valid = 4'b1000; req_a[15:12] = 4'h7; req_b[15:12] = 4'h2; req_op[3] = 1'b0;
    sample(); chk("midrst_ready", req_ready, 4'b1000);
    tick(); req_valid = '0;
    tick(); reset = 1'b1;
    sample(); chk("midrst_alu_done", alu_done, 1'b1);
    tick(); reset = 1'b0;
    sample();
    chk("midrst_resp_valid",  resp_valid,  4'h0);
    chk("midrst_resp_result", resp_result, 16'h0);
    chk("midrst_alu_valid",   alu_valid,   1'b0);
    chk("midrst_alu_a",       alu_a,       4'h0);
    chk("midrst_alu_b",       alu_b,       4'h0);
    chk("midrst_alu_op",      alu_op,      1'b0);
    chk("midrst_busy",        busy,        1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(); sample();
      chk("midrst_no_resp", resp_valid, 4'h0);
    end

    // NREQ=3: grant to index 2 wraps the pointer back to 0
    tick();
    req_valid3 = 3'b100; req_a3[11:8] = 4'h6; req_b3[11:8] = 4'hC; req_op3[2] = 1'b1;
    sample(); chk("n3_grant2", req_ready3, 3'b100);
    tick(); req_valid3 = 3'b011;
    sample(); chk("n3_wrap_grant0", req_ready3, 3'b001);
    tick();
    sample(); chk("n3_grant1", req_ready3, 3'b010);
    tick(); req_valid3 = '0;
    sample(); chk("n3_resp2_valid", resp_valid3, 3'b100);
    chk("n3_resp2_result", resp_result3[11:8], 4'hC);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have ended", $time);
    $fatal(1, "watchdog timeout");
  end

endmodule
